// File: rtl/audio_pkg.sv
// Shared types for the codec audio DAC path: channel state and the stereo FIFO entry.
package audio_pkg;

   localparam int AUDIO_SAMPLE_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      LEFT,
      RIGHT
   } dac_state_t;

   typedef struct packed {
      logic [AUDIO_SAMPLE_W-1:0] l;
      logic [AUDIO_SAMPLE_W-1:0] r;
   } stereo_sample_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO on CLOCK_50 with a synchronous flush that overrides push and pop.
import audio_pkg::*;

module audio_sample_fifo #(
   parameter int DEPTH = 128
) (
   input  logic                   CLOCK_50,
   input  logic                   reset_n,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  stereo_sample_t         wr_data,
   output stereo_sample_t         rd_data,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   stereo_sample_t mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           push_ok;
   logic           pop_ok;

   assign full    = (level == DEPTH_CNT);
   assign empty   = (level == '0);
   assign push_ok = push & ~full;
   // a pop against an empty FIFO is simply refused, so a push in the same cycle is still stored
   assign pop_ok  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (push_ok && !clear) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/audio_dac_serializer.sv
// Left-justified stereo DAC serializer: codec-mastered BCLK/LRCK, FIFO-fed, MSB first.
//
//   state | meaning
//   IDLE  | no frame started since reset, DACDAT held low
//   LEFT  | shifting the left word (LRCK high)
//   RIGHT | shifting the right word (LRCK low)
import audio_pkg::*;

module audio_dac_serializer #(
   parameter int DATA_WIDTH  = 32,
   parameter int FIFO_DEPTH  = 128,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          CLOCK_50,
   input  logic                          reset_n,
   input  logic                          clear_audio_out_memory,
   input  logic [31:0]                   left_channel_audio_out,
   input  logic [31:0]                   right_channel_audio_out,
   input  logic                          write_audio_out,
   output logic                          audio_out_allowed,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   underrun_count,
   input  logic                          AUD_BCLK,
   input  logic                          AUD_DACLRCK,
   output logic                          AUD_DACDAT
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   logic [SYNC_STAGES-1:0] bclk_sync;
   logic [SYNC_STAGES-1:0] lr_sync;
   logic                   bclk_d;
   logic                   lr_d;
   logic                   bclk_s;
   logic                   lr_s;
   logic                   bclk_fall;
   logic                   lr_rise;
   logic                   lr_fall;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         bclk_sync <= '0;
         lr_sync   <= '0;
         bclk_d    <= 1'b0;
         lr_d      <= 1'b0;
      end else begin
         bclk_sync[0] <= AUD_BCLK;
         lr_sync[0]   <= AUD_DACLRCK;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            bclk_sync[i] <= bclk_sync[i-1];
            lr_sync[i]   <= lr_sync[i-1];
         end
         bclk_d <= bclk_s;
         lr_d   <= lr_s;
      end
   end

   assign bclk_s    = bclk_sync[SYNC_STAGES-1];
   assign lr_s      = lr_sync[SYNC_STAGES-1];
   assign bclk_fall = bclk_d & ~bclk_s;
   assign lr_rise   = ~lr_d & lr_s;
   assign lr_fall   = lr_d & ~lr_s;

   stereo_sample_t wr_sample;
   stereo_sample_t rd_sample;
   logic           fifo_pop;
   logic           fifo_full;
   logic           fifo_empty;

   assign wr_sample.l = left_channel_audio_out;
   assign wr_sample.r = right_channel_audio_out;

   audio_sample_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .clear    (clear_audio_out_memory),
      .push     (write_audio_out),
      .pop      (fifo_pop),
      .wr_data  (wr_sample),
      .rd_data  (rd_sample),
      .level    (fifo_level),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign audio_out_allowed = ~fifo_full;

   logic [DATA_WIDTH-1:0] head_l;
   logic [DATA_WIDTH-1:0] head_r;

   assign head_l = rd_sample.l[AUDIO_SAMPLE_W-1 -: DATA_WIDTH];
   assign head_r = rd_sample.r[AUDIO_SAMPLE_W-1 -: DATA_WIDTH];

   dac_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
   logic [CW-1:0]         bits_left_q, bits_left_d;
   logic [15:0]           underrun_q, underrun_d;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         hold_r_q    <= '0;
         bits_left_q <= '0;
         underrun_q  <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_r_q    <= hold_r_d;
         bits_left_q <= bits_left_d;
         underrun_q  <= underrun_d;
      end
   end

   // LR edges take precedence over a coincident BCLK fall: the codec moves LRCK on that edge
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_r_d    = hold_r_q;
      bits_left_d = bits_left_q;
      underrun_d  = underrun_q;
      fifo_pop    = 1'b0;

      if (lr_rise) begin
         state_d     = LEFT;
         bits_left_d = LAST_BIT;
         if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = head_l;
            hold_r_d = head_r;
         end else begin
            shift_d  = '0;
            hold_r_d = '0;
            if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
         end
      end else if (lr_fall && state_q == LEFT) begin
         state_d     = RIGHT;
         shift_d     = hold_r_q;
         bits_left_d = LAST_BIT;
      end else if (bclk_fall && state_q != IDLE) begin
         if (bits_left_q != '0) begin
            shift_d     = shift_q << 1;
            bits_left_d = bits_left_q - CW'(1);
         end else begin
            shift_d = '0;
         end
      end
   end

   assign AUD_DACDAT     = shift_q[DATA_WIDTH-1];
   assign underrun_count = underrun_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: drives a codec-style BCLK/LRCK and captures DACDAT on BCLK rises.
module tb_audio_dac_serializer;

   logic        CLOCK_50 = 1'b0;
   logic        reset_n  = 1'b0;
   logic        clear    = 1'b0;
   logic        write_en = 1'b0;
   logic [31:0] left_in  = '0;
   logic [31:0] right_in = '0;
   logic        bclk     = 1'b1;
   logic        lrck     = 1'b0;
   logic        allowed;
   logic [7:0]  level;
   logic [15:0] underruns;
   logic        dacdat;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] left_cap;
   logic [31:0] right_cap;

   audio_dac_serializer dut (
      .CLOCK_50                (CLOCK_50),
      .reset_n                 (reset_n),
      .clear_audio_out_memory  (clear),
      .left_channel_audio_out  (left_in),
      .right_channel_audio_out (right_in),
      .write_audio_out         (write_en),
      .audio_out_allowed       (allowed),
      .fifo_level              (level),
      .underrun_count          (underruns),
      .AUD_BCLK                (bclk),
      .AUD_DACLRCK             (lrck),
      .AUD_DACDAT              (dacdat)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic push(input logic [31:0] l, input logic [31:0] r);
      @(negedge CLOCK_50);
      left_in  = l;
      right_in = r;
      write_en = 1'b1;
      @(negedge CLOCK_50);
      write_en = 1'b0;
   endtask

   // codec edges land 3 ns after a CLOCK_50 falling edge, clear of the sampling edge
   task automatic align();
      @(negedge CLOCK_50);
      #3;
   endtask

   // one 64-BCLK LRCK period; LRCK and data change on BCLK fall, DACDAT captured on BCLK rise
   task automatic run_frame();
      for (int i = 0; i < 64; i++) begin
         bclk = 1'b0;
         if (i == 0) lrck = 1'b1;
         else if (i == 32) lrck = 1'b0;
         #160;
         bclk = 1'b1;
         if (i < 32) left_cap[31-i] = dacdat;
         else        right_cap[63-i] = dacdat;
         #160;
      end
   endtask

   initial begin
      #55;
      check("rst_dacdat",    32'(dacdat),    32'h0);
      check("rst_allowed",   32'(allowed),   32'h1);
      check("rst_level",     32'(level),     32'h0);
      check("rst_underrun",  32'(underruns), 32'h0);
      reset_n = 1'b1;

      // idle codec, nothing queued: every frame is zeros and counts an underrun
      for (int f = 0; f < 5; f++) begin
         align();
         run_frame();
         check("idle_left",  left_cap,  32'h0);
         check("idle_right", right_cap, 32'h0);
      end
      check("idle_underrun", 32'(underruns), 32'd5);

      // single frame, MSB-first, exact bits
      push(32'h8000_0001, 32'h7FFF_FFFE);
      check("single_level_pre", 32'(level), 32'd1);
      align();
      run_frame();
      check("single_left",       left_cap,        32'h8000_0001);
      check("single_right",      right_cap,       32'h7FFF_FFFE);
      check("single_level_post", 32'(level),      32'd0);
      check("single_underrun",   32'(underruns),  32'd5);

      // fill to full, then an overflow push is dropped
      for (int k = 1; k <= 128; k++) begin
         push(32'h1000_0000 + 32'(k), ~(32'h1000_0000 + 32'(k)));
         if (k == 127) check("fill_allowed_127", 32'(allowed), 32'h1);
      end
      check("full_allowed", 32'(allowed), 32'h0);
      check("full_level",   32'(level),   32'd128);
      push(32'hDEAD_BEEF, 32'hDEAD_BEEF);
      check("overflow_level", 32'(level), 32'd128);
      align();
      run_frame();
      check("full_pop_left",  left_cap,      32'h1000_0001);
      check("full_pop_right", right_cap,     32'hEFFF_FFFE);
      check("full_pop_level", 32'(level),    32'd127);
      check("full_pop_allow", 32'(allowed),  32'h1);
      @(negedge CLOCK_50);
      clear = 1'b1;
      @(negedge CLOCK_50);
      clear = 1'b0;
      check("flush_level",    32'(level),     32'd0);
      check("flush_underrun", 32'(underruns), 32'd5);

      // push landing in the same cycle as lr_rise on an empty FIFO
      align();
      fork
         run_frame();
         begin
            @(negedge CLOCK_50);
            @(negedge CLOCK_50);
            left_in  = 32'hCAFE_BABE;
            right_in = 32'h1234_5678;
            write_en = 1'b1;
            @(negedge CLOCK_50);
            write_en = 1'b0;
         end
      join
      check("coinc_left",     left_cap,       32'h0);
      check("coinc_right",    right_cap,      32'h0);
      check("coinc_underrun", 32'(underruns), 32'd6);
      check("coinc_level",    32'(level),     32'd1);
      align();
      run_frame();
      check("coinc_next_left",  left_cap,       32'hCAFE_BABE);
      check("coinc_next_right", right_cap,      32'h1234_5678);
      check("coinc_next_level", 32'(level),     32'd0);
      check("coinc_next_under", 32'(underruns), 32'd6);

      // flush during the left half: current word still completes
      push(32'hA5A5_0F0F, 32'h5A5A_F0F0);
      push(32'h1111_1111, 32'h2222_2222);
      push(32'h3333_3333, 32'h4444_4444);
      check("clr_level_pre", 32'(level), 32'd3);
      align();
      fork
         run_frame();
         begin
            #(320 * 10 + 50);
            @(negedge CLOCK_50);
            clear = 1'b1;
            @(negedge CLOCK_50);
            clear = 1'b0;
            check("clr_level_mid", 32'(level), 32'd0);
         end
      join
      check("clr_left",  left_cap,  32'hA5A5_0F0F);
      check("clr_right", right_cap, 32'h5A5A_F0F0);
      align();
      run_frame();
      check("clr_next_left",  left_cap,       32'h0);
      check("clr_next_under", 32'(underruns), 32'd7);

      // asynchronous reset during the right half, between CLOCK_50 edges
      push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      push(32'h0F0F_0F0F, 32'hF0F0_F0F0);
      align();
      fork
         run_frame();
         begin
            #(320 * 44 + 50);
            reset_n = 1'b0;
            #1;
            check("arst_dacdat",   32'(dacdat),    32'h0);
            check("arst_level",    32'(level),     32'h0);
            check("arst_underrun", 32'(underruns), 32'h0);
            check("arst_allowed",  32'(allowed),   32'h1);
            #(320 * 6);
            reset_n = 1'b1;
         end
      join
      check("arst_left",  left_cap,  32'hFFFF_FFFF);
      check("arst_right", right_cap, 32'hFFF0_0000);
      align();
      run_frame();
      check("arst_next_left",  left_cap,       32'h0);
      check("arst_next_right", right_cap,      32'h0);
      check("arst_next_under", 32'(underruns), 32'd1);
      push(32'h8765_4321, 32'h0BAD_F00D);
      align();
      run_frame();
      check("arst_resume_left",  left_cap,  32'h8765_4321);
      check("arst_resume_right", right_cap, 32'h0BAD_F00D);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
